// File: rtl/gaussian_line_buffer_pkg.sv
// Shared constants and helpers for the Gaussian window line buffer.
package gaussian_line_buffer_pkg;

  localparam int PIX_W       = 9;
  localparam int KERNEL_SIZE = 7;
  localparam int BUF_LINES   = KERNEL_SIZE - 1;

  // Index of one of the BUF_LINES line RAMs in the ring.
  typedef logic [2:0] wsel_t;

  // Ring position k steps after base, modulo BUF_LINES (base < BUF_LINES, k < BUF_LINES).
  function automatic wsel_t ring_add(input wsel_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= BUF_LINES) s = s - BUF_LINES;
    return wsel_t'(s);
  endfunction

endpackage

// File: rtl/gaussian_line_buffer_if.sv
// Pixel-in / window-out bundle between the pixel source and the Gaussian filter.
// Handshake: valid-only. iDval marks a pixel that is consumed in that cycle
// (there is no ready, the buffer always accepts); oRead_en marks a window the
// filter must consume in that cycle. iFrame_start qualifies the pixel presented
// with it as row 0, col 0 of a new frame.
interface gaussian_line_buffer_if #(
  parameter int DATA_W  = 9,
  parameter int COORD_W = 10
);
  logic               iFrame_start;
  logic               iDval;
  logic [DATA_W-1:0]  iPixel;
  logic               oRead_en;
  logic [DATA_W-1:0]  oLine0;
  logic [DATA_W-1:0]  oLine1;
  logic [DATA_W-1:0]  oLine2;
  logic [DATA_W-1:0]  oLine3;
  logic [DATA_W-1:0]  oLine4;
  logic [DATA_W-1:0]  oLine5;
  logic [DATA_W-1:0]  oLine6;
  logic [COORD_W-1:0] oRow;
  logic [COORD_W-1:0] oCol;

  modport master (
    output iFrame_start, iDval, iPixel,
    input  oRead_en, oLine0, oLine1, oLine2, oLine3, oLine4, oLine5, oLine6, oRow, oCol
  );

  modport slave (
    input  iFrame_start, iDval, iPixel,
    output oRead_en, oLine0, oLine1, oLine2, oLine3, oLine4, oLine5, oLine6, oRow, oCol
  );
endinterface

// File: rtl/gaussian_line_buffer_line_ram.sv
// Single-port, read-first, synchronous-read line RAM. Contents are never
// cleared; only the read register is reset so the taps come up as zero.
module gaussian_line_buffer_line_ram #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 10
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the new pixel when this RAM is the one being refilled.
  always_ff @(posedge iclk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read port: returns the pre-write contents; holds on idle cycles.
  always_ff @(posedge iclk) begin
    if (irst)    rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/gaussian_line_buffer.sv
// Six-line ring buffer producing seven vertically aligned taps per accepted
// pixel for the 7x7 Gaussian filter. Taps appear one cycle after acceptance.
module gaussian_line_buffer
  import gaussian_line_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = PIX_W,
  parameter int COORD_W    = 10
) (
  input  logic                    iclk,
  input  logic                    irst,
  gaussian_line_buffer_if.slave   bus
);

  localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  // Raster position and ring pointer of the next pixel to arrive.
  logic [COORD_W-1:0] col_q, row_q;
  wsel_t              wsel_q;
  logic [COORD_W-1:0] col_d, row_d;
  wsel_t              wsel_d;

  // Position of the pixel in this cycle after a possible frame restart.
  logic [COORD_W-1:0] eff_col, eff_row;
  wsel_t              eff_wsel;
  logic               col_last, row_last, accept;

  // Output-side state, all captured at acceptance time.
  logic               read_en_q;
  wsel_t              tap_sel_q;
  logic [DATA_W-1:0]  line6_q;
  logic [COORD_W-1:0] out_row_q, out_col_q;

  logic [DATA_W-1:0]  rd_data [BUF_LINES];
  logic [DATA_W-1:0]  taps    [BUF_LINES];

  assign accept   = bus.iDval && !irst;
  assign eff_col  = bus.iFrame_start ? '0 : col_q;
  assign eff_row  = bus.iFrame_start ? '0 : row_q;
  assign eff_wsel = bus.iFrame_start ? '0 : wsel_q;
  assign col_last = (eff_col == COORD_W'(IMG_WIDTH - 1));
  assign row_last = (eff_row == COORD_W'(IMG_HEIGHT - 1));

  // Next raster position: advance on a pixel, zero on a bare frame start, else hold.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    wsel_d = wsel_q;
    if (bus.iDval) begin
      if (col_last) begin
        col_d  = '0;
        row_d  = row_last ? '0 : eff_row + COORD_W'(1);
        wsel_d = (eff_wsel == wsel_t'(BUF_LINES - 1)) ? '0 : eff_wsel + wsel_t'(1);
      end else begin
        col_d  = eff_col + COORD_W'(1);
        row_d  = eff_row;
        wsel_d = eff_wsel;
      end
    end else if (bus.iFrame_start) begin
      col_d  = '0;
      row_d  = '0;
      wsel_d = '0;
    end
  end

  // Raster position register.
  always_ff @(posedge iclk) begin
    if (irst) begin
      col_q  <= '0;
      row_q  <= '0;
      wsel_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      wsel_q <= wsel_d;
    end
  end

  // Every RAM is read at the current column; only the ring head is rewritten.
  for (genvar i = 0; i < BUF_LINES; i++) begin : g_line
    gaussian_line_buffer_line_ram #(
      .DEPTH  (IMG_WIDTH),
      .WIDTH  (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .iclk  (iclk),
      .irst  (irst),
      .en    (accept),
      .we    (eff_wsel == wsel_t'(i)),
      .addr  (eff_col[ADDR_W-1:0]),
      .wdata (bus.iPixel),
      .rdata (rd_data[i])
    );
  end

  // Output registers: window valid only once six fresh rows sit in the ring.
  always_ff @(posedge iclk) begin
    if (irst) begin
      read_en_q <= 1'b0;
      tap_sel_q <= '0;
      line6_q   <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else if (bus.iDval) begin
      read_en_q <= (eff_row >= COORD_W'(BUF_LINES));
      tap_sel_q <= eff_wsel;
      line6_q   <= bus.iPixel;
      out_row_q <= eff_row;
      out_col_q <= eff_col;
    end else begin
      read_en_q <= 1'b0;
    end
  end

  // Rotate RAM outputs so tap 0 is the oldest row, starting from the ring head.
  always_comb begin
    for (int k = 0; k < BUF_LINES; k++) begin
      taps[k] = rd_data[ring_add(tap_sel_q, k)];
    end
  end

  assign bus.oRead_en = read_en_q;
  assign bus.oLine0   = taps[0];
  assign bus.oLine1   = taps[1];
  assign bus.oLine2   = taps[2];
  assign bus.oLine3   = taps[3];
  assign bus.oLine4   = taps[4];
  assign bus.oLine5   = taps[5];
  assign bus.oLine6   = line6_q;
  assign bus.oRow     = out_row_q;
  assign bus.oCol     = out_col_q;

endmodule

// File: tb/tb_gaussian_line_buffer.sv
// Bench for gaussian_line_buffer: directed raster streams plus a random phase,
// checked against a row-history reference model through an expected queue.
module tb_gaussian_line_buffer;

  localparam int W  = 8;
  localparam int H  = 10;
  localparam int DW = 9;
  localparam int CW = 10;
  localparam int NL = 6;

  // ---------------- clock / reset ----------------
  logic iclk = 1'b0;
  logic irst;
  always #5 iclk = ~iclk;

  gaussian_line_buffer_if #(.DATA_W(DW), .COORD_W(CW)) bus ();

  gaussian_line_buffer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (DW),
    .COORD_W    (CW)
  ) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic           en;
    logic           taps_known;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic [DW-1:0]  l6;
    logic [NL*DW-1:0] taps;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];

  typedef logic [W*DW-1:0] rowpack_t;
  rowpack_t hist[$];        // last completed rows since restart, oldest first
  rowpack_t cur_row;
  int       m_row, m_col;
  exp_t     last_exp;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  task automatic model_step(input logic rst, input logic fs, input logic dv,
                            input logic [DW-1:0] pix);
    exp_t e;
    e = '0;
    if (rst) begin
      m_row = 0;
      m_col = 0;
      hist.delete();
      cur_row = '0;
      e.taps_known = 1'b1;   // all outputs zero after reset
    end else begin
      if (fs) begin
        m_row = 0;
        m_col = 0;
        hist.delete();
      end
      if (dv) begin
        e.en  = (m_row >= NL);
        e.row = CW'(m_row);
        e.col = CW'(m_col);
        e.l6  = pix;
        e.taps_known = (hist.size() == NL);
        if (e.taps_known) begin
          for (int k = 0; k < NL; k++) e.taps[k*DW +: DW] = hist[k][m_col*DW +: DW];
        end
        cur_row[m_col*DW +: DW] = pix;
        if (m_col == W - 1) begin
          hist.push_back(cur_row);
          if (hist.size() > NL) void'(hist.pop_front());
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end else begin
        e = last_exp;
        e.en = 1'b0;
      end
    end
    last_exp = e;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic fs, input logic dv,
                       input logic [DW-1:0] pix);
    @(negedge iclk);
    irst             = rst;
    bus.iFrame_start = fs;
    bus.iDval        = dv;
    bus.iPixel       = pix;
    model_step(rst, fs, dv, pix);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, DW'($urandom_range(0, 511)));
  endtask

  // Rows r0..r0+nrows-1 with value base + r*16 + c; optional 5-cycle gaps after each pixel of gap_row.
  task automatic stream_rows(input int r0, input int nrows, input logic fs_first,
                             input int gap_row, input int base);
    for (int r = r0; r < r0 + nrows; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b0, fs_first && (r == r0) && (c == 0), 1'b1, DW'(base + r * 16 + c));
        if (r == gap_row) bubbles(5);
      end
    end
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp_v, $time);
    end
  endtask

  initial begin
    exp_t e;
    logic [DW-1:0] act_taps [NL];
    forever begin
      @(posedge iclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_taps[0] = bus.oLine0;
        act_taps[1] = bus.oLine1;
        act_taps[2] = bus.oLine2;
        act_taps[3] = bus.oLine3;
        act_taps[4] = bus.oLine4;
        act_taps[5] = bus.oLine5;
        chk("read_en", 16'(bus.oRead_en), 16'(e.en));
        chk("row",     16'(bus.oRow),     16'(e.row));
        chk("col",     16'(bus.oCol),     16'(e.col));
        chk("line6",   16'(bus.oLine6),   16'(e.l6));
        if (e.taps_known) begin
          for (int k = 0; k < NL; k++) begin
            chk($sformatf("line%0d", k), 16'(act_taps[k]), 16'(e.taps[k*DW +: DW]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    irst             = 1'b1;
    bus.iFrame_start = 1'b0;
    bus.iDval        = 1'b0;
    bus.iPixel       = '0;
    last_exp         = '0;
    cur_row          = '0;
    m_row            = 0;
    m_col            = 0;

    // Reset with random inputs on the bus.
    drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 511)));
    bubbles(2);

    // Frame start, rows 0..6, then row 7 with gaps, then rows 8..9.
    stream_rows(0, 7, 1'b1, -1, 0);
    stream_rows(7, 1, 1'b0, 7, 0);
    stream_rows(8, 2, 1'b0, -1, 0);
    // Next frame without a frame-start pulse: row wraps and rows 0..5 refill.
    stream_rows(0, 7, 1'b0, -1, 0);
    bubbles(3);

    // Mid-frame restart at (4,2).
    stream_rows(0, 4, 1'b1, -1, 0);
    drive(1'b0, 1'b0, 1'b1, DW'(4 * 16 + 0));
    drive(1'b0, 1'b0, 1'b1, DW'(4 * 16 + 1));
    drive(1'b0, 1'b1, 1'b1, DW'(4 * 16 + 2));
    for (int c = 3; c < W; c++) drive(1'b0, 1'b0, 1'b1, DW'(4 * 16 + c));
    stream_rows(5, 7, 1'b0, -1, 0);
    bubbles(2);

    // Reset at row 7 col 4, then a fresh stream (bit 8 set) without frame start.
    stream_rows(0, 7, 1'b1, -1, 0);
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 1'b1, DW'(7 * 16 + c));
    drive(1'b1, 1'b0, 1'b1, DW'(7 * 16 + 4));
    stream_rows(0, 8, 1'b0, -1, 256);
    bubbles(2);

    // Random traffic with occasional frame starts and resets.
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 149) == 0),
            1'($urandom_range(0, 3) != 0),
            DW'($urandom_range(0, 511)));
    end
    bubbles(3);

    // Bounded drain of the expected queue.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge iclk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
